// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared glyph table, FSM state type and nibble width for seg_scan_reader
package seg_scan_pkg;

   localparam int NIBBLE_W = 4;

   // Active-low segment patterns (bit 0 = a ... bit 6 = g), indexed by hex value
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {SCAN, HOLD} state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational active-low 7-segment pattern to hex nibble lookup
//   pattern : segment pattern a..g on bits 0..6, active-low
//   nibble  : decoded hex value, 0 when the pattern is not a glyph
//   err     : set when the pattern matches no glyph
module seg_glyph_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0]          pattern,
   output logic [NIBBLE_W-1:0] nibble,
   output logic                err
);

   always_comb begin
      nibble = '0;
      err    = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (pattern == GLYPH[k]) begin
            nibble = NIBBLE_W'(k);
            err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - recovers hex digits from a multiplexed active-low 7-segment bus into frames
//   Clock, Reset : single clock, synchronous active-high reset
//   seg_n        : segments a..g, active-low, asynchronous
//   dig_sel_n    : digit enables, active-low one-hot, asynchronous
//   out_data     : frame, digit i at [4i+3:4i]
//   out_err      : per-digit illegal-glyph flags
//   out_valid    : frame available, out_ready : consumer accepts
//   overrun      : sticky, a completed frame was dropped
//   SEG_SCAN_DP_EN : adds dp_n input and out_dp per-digit decimal-point output
module seg_scan_reader
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 3
)(
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [6:0]                     seg_n,
   input  logic [NUM_DIGITS-1:0]          dig_sel_n,
`ifdef SEG_SCAN_DP_EN
   input  logic                           dp_n,
   output logic [NUM_DIGITS-1:0]          out_dp,
`endif
   output logic [NUM_DIGITS*NIBBLE_W-1:0] out_data,
   output logic [NUM_DIGITS-1:0]          out_err,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overrun
);

   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

`ifdef SEG_SCAN_DP_EN
   localparam int PW = 8;
   logic [PW-1:0] pat_raw;
   assign pat_raw = {dp_n, seg_n};
   logic [NUM_DIGITS-1:0] frame_dp;
`else
   localparam int PW = 7;
   logic [PW-1:0] pat_raw;
   assign pat_raw = seg_n;
`endif

   logic [PW-1:0]                  pat_s1, pat_s2, pat_p;
   logic [NUM_DIGITS-1:0]          sel_s1, sel_s2, sel_p, sel_hot;
   logic                           sel_valid, changed, capture, frame_full;
   logic [7:0]                     cnt, cnt_next;
   state_t                         state, state_next;
   logic [NIBBLE_W-1:0]            nib;
   logic                           nib_err;
   logic [NUM_DIGITS-1:0]          mask, mask_next, frame_err;
   logic [NUM_DIGITS*NIBBLE_W-1:0] frame_data;

   // Two-flop synchronizers plus a third stage holding the previous synchronized value
   always_ff @(posedge Clock) begin
      if (Reset) begin
         pat_s1 <= '1;
         pat_s2 <= '1;
         pat_p  <= '1;
         sel_s1 <= '1;
         sel_s2 <= '1;
         sel_p  <= '1;
      end else begin
         pat_s1 <= pat_raw;
         pat_s2 <= pat_s1;
         pat_p  <= pat_s2;
         sel_s1 <= dig_sel_n;
         sel_s2 <= sel_s1;
         sel_p  <= sel_s2;
      end
   end

   assign sel_hot   = ~sel_s2;
   assign sel_valid = (sel_hot != '0) && ((sel_hot & (sel_hot - NUM_DIGITS'(1))) == '0);
   assign changed   = (pat_s2 != pat_p) || (sel_s2 != sel_p);

   always_comb begin
      cnt_next = cnt;
      if (!sel_valid || changed) begin
         cnt_next = '0;
      end else if (cnt != SETTLE) begin
         cnt_next = cnt + 8'd1;
      end
   end

   seg_glyph_decode u_decode (
      .pattern (pat_s2[6:0]),
      .nibble  (nib),
      .err     (nib_err)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= SCAN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Capture on the same edge the counter reaches SETTLE so pin-to-capture is sync + SETTLE + 1
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         SCAN: begin
            if (sel_valid && !changed && cnt_next == SETTLE) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (changed) state_next = SCAN;
         end
         default: state_next = SCAN;
      endcase
   end

   assign frame_full = &mask;

   always_comb begin
      mask_next = frame_full ? '0 : mask;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (capture && sel_hot[d]) mask_next[d] = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         mask       <= '0;
         frame_data <= '0;
         frame_err  <= '0;
`ifdef SEG_SCAN_DP_EN
         frame_dp   <= '0;
`endif
      end else begin
         mask <= mask_next;
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (capture && sel_hot[d]) begin
               frame_data[d*NIBBLE_W +: NIBBLE_W] <= nib;
               frame_err[d]                       <= nib_err;
`ifdef SEG_SCAN_DP_EN
               frame_dp[d]                        <= pat_s2[7];
`endif
            end
         end
      end
   end

   // A completed frame loads only if the output slot is empty or being drained this cycle
   always_ff @(posedge Clock) begin
      if (Reset) begin
         out_data  <= '0;
         out_err   <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
`ifdef SEG_SCAN_DP_EN
         out_dp    <= '0;
`endif
      end else if (frame_full) begin
         if (!out_valid || out_ready) begin
            out_data  <= frame_data;
            out_err   <= frame_err;
            out_valid <= 1'b1;
`ifdef SEG_SCAN_DP_EN
            out_dp    <= frame_dp;
`endif
         end else begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - self-checking bench for seg_scan_reader
module tb_seg_scan_reader;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel_n;
   logic [15:0] out_data;
   logic [3:0]  out_err;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
`ifdef SEG_SCAN_DP_EN
   logic        dp_n = 1'b1;
   logic [3:0]  out_dp;
`endif

   int checks = 0;
   int errors = 0;
   int xfers = 0;
   int valid_cycles = 0;
   logic [15:0] last_data = '0;
   logic [3:0]  last_err = '0;

   typedef struct {
      logic [27:0] pats;
      logic [15:0] exp_data;
      logic [3:0]  exp_err;
   } vec_t;

   vec_t vecs [5];

   seg_scan_reader #(.NUM_DIGITS(4), .SETTLE_CYCLES(3)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .seg_n     (seg_n),
      .dig_sel_n (dig_sel_n),
`ifdef SEG_SCAN_DP_EN
      .dp_n      (dp_n),
      .out_dp    (out_dp),
`endif
      .out_data  (out_data),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      #1;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
         xfers++;
         last_data = out_data;
         last_err  = out_err;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic show(input int d, input logic [6:0] p, input int n);
      dig_sel_n = ~(4'b0001 << d);
      seg_n     = p;
      repeat (n) @(negedge Clock);
   endtask

   task automatic idle(input int n);
      dig_sel_n = 4'hF;
      seg_n     = 7'h7F;
      repeat (n) @(negedge Clock);
   endtask

   task automatic run_frame(input logic [27:0] pats);
      for (int d = 0; d < 4; d++) show(d, pats[d*7 +: 7], 10);
   endtask

   initial begin
      int x0;
      int v0;
      int lat;

      vecs[0] = '{{7'h0E, 7'h19, 7'h30, 7'h24}, 16'hF432, 4'b0000};
      vecs[1] = '{{7'h46, 7'h12, 7'h7F, 7'h40}, 16'hC500, 4'b0010};
      vecs[2] = '{{7'h03, 7'h08, 7'h79, 7'h00}, 16'hBA18, 4'b0000};
      vecs[3] = '{{7'h21, 7'h18, 7'h78, 7'h02}, 16'hD976, 4'b0000};
      vecs[4] = '{{7'h40, 7'h55, 7'h00, 7'h06}, 16'h008E, 4'b0100};

      Reset     = 1'b1;
      out_ready = 1'b1;
      dig_sel_n = 4'hF;
      seg_n     = 7'h7F;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      chk("reset_data", 32'(out_data), 32'h0);
      chk("reset_err", 32'(out_err), 32'h0);
      chk("reset_valid", 32'(out_valid), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      idle(4);

      for (int i = 0; i < 5; i++) begin
         x0 = xfers;
         v0 = valid_cycles;
         run_frame(vecs[i].pats);
         idle(8);
         chk($sformatf("vec%0d_xfers", i), 32'(xfers - x0), 32'd1);
         chk($sformatf("vec%0d_valid_pulse", i), 32'(valid_cycles - v0), 32'd1);
         chk($sformatf("vec%0d_data", i), 32'(last_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
      end

      // latency from digit3 pin change to out_valid: 2 sync + 3 settle + 1 capture + 1 load
      show(0, 7'h24, 10);
      show(1, 7'h30, 10);
      show(2, 7'h19, 10);
      dig_sel_n = 4'b0111;
      seg_n     = 7'h0E;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clock);
         if (out_valid && lat == 0) lat = c;
      end
      chk("latency", 32'(lat), 32'd7);
      chk("latency_data", 32'(last_data), 32'hF432);
      idle(8);

      // settle rejection
      x0 = xfers;
      show(0, 7'h40, 10);
      show(1, 7'h79, 10);
      show(2, 7'h24, 2);
      idle(10);
      show(3, 7'h30, 10);
      idle(8);
      chk("settle_short_nocap", 32'(xfers - x0), 32'd0);
      show(2, 7'h19, 6);
      idle(8);
      chk("settle_long_cap", 32'(xfers - x0), 32'd1);
      chk("settle_data", 32'(last_data), 32'h3410);
      chk("settle_err", 32'(last_err), 32'h0);

      // multi-select ignored
      x0 = xfers;
      show(1, 7'h24, 10);
      show(2, 7'h30, 10);
      show(3, 7'h19, 10);
      dig_sel_n = 4'b1100;
      seg_n     = 7'h7F;
      repeat (20) @(negedge Clock);
      idle(8);
      chk("multi_nocap", 32'(xfers - x0), 32'd0);
      show(0, 7'h0E, 10);
      idle(8);
      chk("multi_then_xfer", 32'(xfers - x0), 32'd1);
      chk("multi_data", 32'(last_data), 32'h432F);
      chk("multi_err", 32'(last_err), 32'h0);

      // backpressure and overrun
      out_ready = 1'b0;
      run_frame(vecs[2].pats);
      idle(8);
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      chk("bp_first_data", 32'(out_data), 32'hBA18);
      chk("bp_no_overrun_yet", 32'(overrun), 32'd0);
      run_frame(vecs[3].pats);
      idle(8);
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_held_data", 32'(out_data), 32'hBA18);
      chk("bp_overrun", 32'(overrun), 32'd1);
      x0 = xfers;
      out_ready = 1'b1;
      idle(4);
      chk("bp_drain_xfers", 32'(xfers - x0), 32'd1);
      chk("bp_drain_data", 32'(last_data), 32'hBA18);
      chk("bp_drain_valid", 32'(out_valid), 32'd0);
      chk("bp_overrun_sticky", 32'(overrun), 32'd1);

      // reset mid-frame
      show(0, 7'h12, 10);
      show(1, 7'h12, 10);
      dig_sel_n = 4'hF;
      seg_n     = 7'h7F;
      Reset     = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      chk("rst_mid_overrun", 32'(overrun), 32'd0);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_data", 32'(out_data), 32'h0);
      idle(4);
      x0 = xfers;
      show(2, 7'h24, 10);
      show(3, 7'h30, 10);
      idle(8);
      chk("rst_partial_discarded", 32'(xfers - x0), 32'd0);
      show(0, 7'h79, 10);
      show(1, 7'h19, 10);
      idle(8);
      chk("rst_fresh_xfer", 32'(xfers - x0), 32'd1);
      chk("rst_fresh_data", 32'(last_data), 32'h3241);
      chk("rst_fresh_err", 32'(last_err), 32'h0);
      chk("rst_fresh_overrun", 32'(overrun), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
